// File: rtl/sfp_ctrl_if.sv
// Control bundle between the SFP sequencer and its job master, OFIFO read side,
// PSUM SRAM control port and SFP column mode inputs.
interface sfp_ctrl_if #(
  parameter int addr_bw = 11,
  parameter int pass_bw = 4
);
  logic               start;
  logic [addr_bw-1:0] num_rows;
  logic [pass_bw-1:0] num_passes;
  logic [addr_bw-1:0] base_addr;
  logic               relu_en;
  logic               pass_mode;
  logic               ofifo_valid;
  logic               ofifo_rd;
  logic               sram_cen;
  logic               sram_wen;
  logic [addr_bw-1:0] sram_addr;
  logic               sfp_accum;
  logic               sfp_relu;
  logic               sfp_passthrough;
  logic [pass_bw-1:0] pass_idx;
  logic               busy;
  logic               done;

  modport master (
    output start, num_rows, num_passes, base_addr, relu_en, pass_mode, ofifo_valid,
    input  ofifo_rd, sram_cen, sram_wen, sram_addr, sfp_accum, sfp_relu,
           sfp_passthrough, pass_idx, busy, done
  );

  modport slave (
    input  start, num_rows, num_passes, base_addr, relu_en, pass_mode, ofifo_valid,
    output ofifo_rd, sram_cen, sram_wen, sram_addr, sfp_accum, sfp_relu,
           sfp_passthrough, pass_idx, busy, done
  );
endinterface

// File: rtl/sfp_ctrl.sv
// SFP post-processing sequencer: drains OFIFO rows into PSUM SRAM with a
// read-modify-write per row, accumulating across kernel passes.
module sfp_ctrl #(
  parameter int addr_bw = 11,
  parameter int pass_bw = 4
) (
  input  logic        clk,
  input  logic        reset,
  sfp_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t             state, state_d;
  logic [addr_bw-1:0] row_cnt;
  logic [pass_bw-1:0] pass_cnt;
  logic [addr_bw-1:0] nr_q;
  logic [pass_bw-1:0] np_q;
  logic [addr_bw-1:0] base_q;
  logic               relu_q;
  logic               pm_q;

  logic               load, row_inc, row_clr, pass_inc;
  logic               ofifo_rd, cen, wen, done;
  logic [addr_bw-1:0] addr;
  logic [addr_bw-1:0] row_addr;
  logic [addr_bw-1:0] row_last_val;
  logic [pass_bw-1:0] pass_last_val;
  logic               row_last, pass_last, accum;

  assign row_addr      = base_q + row_cnt;
  assign row_last_val  = nr_q - addr_bw'(1);
  assign pass_last_val = np_q - pass_bw'(1);
  assign row_last      = (row_cnt == row_last_val);
  assign pass_last     = (pass_cnt == pass_last_val);
  assign accum         = !pm_q && (pass_cnt != '0);

  always_comb begin
    state_d  = state;
    load     = 1'b0;
    row_inc  = 1'b0;
    row_clr  = 1'b0;
    pass_inc = 1'b0;
    ofifo_rd = 1'b0;
    cen      = 1'b1;
    wen      = 1'b1;
    addr     = '0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          load = 1'b1;
          if (bus.num_rows == '0 || bus.num_passes == '0) state_d = S_DONE;
          else                                            state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.ofifo_valid) state_d = S_RD;
      end
      S_RD: begin
        addr    = row_addr;
        cen     = !accum;
        state_d = S_WR;
      end
      S_WR: begin
        ofifo_rd = 1'b1;
        cen      = 1'b0;
        wen      = 1'b0;
        addr     = row_addr;
        // A FIFO still reporting data lets the next row start without a WAIT cycle.
        if (!row_last) begin
          row_inc = 1'b1;
          state_d = bus.ofifo_valid ? S_RD : S_WAIT;
        end else if (!pass_last) begin
          row_clr  = 1'b1;
          pass_inc = 1'b1;
          state_d  = bus.ofifo_valid ? S_RD : S_WAIT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      row_cnt  <= '0;
      pass_cnt <= '0;
      nr_q     <= '0;
      np_q     <= '0;
      base_q   <= '0;
      relu_q   <= 1'b0;
      pm_q     <= 1'b0;
    end else begin
      state <= state_d;
      if (load) begin
        nr_q     <= bus.num_rows;
        np_q     <= bus.num_passes;
        base_q   <= bus.base_addr;
        relu_q   <= bus.relu_en;
        pm_q     <= bus.pass_mode;
        row_cnt  <= '0;
        pass_cnt <= '0;
      end else begin
        if (row_inc)  row_cnt  <= row_cnt + addr_bw'(1);
        if (row_clr)  row_cnt  <= '0;
        if (pass_inc) pass_cnt <= pass_cnt + pass_bw'(1);
      end
    end
  end

  assign bus.ofifo_rd        = ofifo_rd;
  assign bus.sram_cen        = cen;
  assign bus.sram_wen        = wen;
  assign bus.sram_addr       = addr;
  assign bus.done            = done;
  assign bus.busy            = (state != S_IDLE);
  assign bus.pass_idx        = pass_cnt;
  assign bus.sfp_passthrough = pm_q;
  assign bus.sfp_accum       = accum;
  assign bus.sfp_relu        = !pm_q && relu_q && pass_last;

endmodule

// File: tb/tb_sfp_ctrl.sv
// Scoreboard bench for sfp_ctrl: expected SRAM/OFIFO/done events are queued by
// the stimulus and matched by a monitor whenever the DUT shows activity.
module tb_sfp_ctrl;
  localparam int AW = 11;
  localparam int PW = 4;
  localparam int K_RD = 0, K_WR = 1, K_DONE = 2;

  typedef struct {
    int cyc;
    int kind;
    int addr;
    int pass;
    bit acc;
    bit relu;
    bit pt;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  int   t0 = 0;
  ev_t  q[$];

  sfp_ctrl_if #(.addr_bw(AW), .pass_bw(PW)) bus ();

  sfp_ctrl #(.addr_bw(AW), .pass_bw(PW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!bus.sram_cen || bus.ofifo_rd || bus.done) begin
      ev_t a, e;
      int  ak, ek_sig, ak_sig;
      ak = bus.done ? K_DONE : (!bus.sram_wen ? K_WR : K_RD);
      a = '{cyc, ak, int'(bus.sram_addr), int'(bus.pass_idx),
            bus.sfp_accum, bus.sfp_relu, bus.sfp_passthrough};
      ak_sig = {28'd0, bus.sram_cen, bus.sram_wen, bus.ofifo_rd, bus.done};
      if (bus.ofifo_rd) pops++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got cyc=%0d kind=%0d addr=%0d pass=%0d, required no activity",
                 a.cyc, a.kind, a.addr, a.pass);
      end else begin
        e = q.pop_front();
        ek_sig = (e.kind == K_RD) ? 4'b0100 : (e.kind == K_WR) ? 4'b0010 : 4'b1101;
        if (a.cyc != e.cyc || ak_sig != ek_sig || a.pass != e.pass ||
            a.acc != e.acc || a.relu != e.relu || a.pt != e.pt ||
            (e.kind != K_DONE && a.addr != e.addr)) begin
          errors++;
          $display("FAIL event: got cyc=%0d cen/wen/rd/done=%b addr=%0d pass=%0d acc=%0b relu=%0b pt=%0b, required cyc=%0d cen/wen/rd/done=%b addr=%0d pass=%0d acc=%0b relu=%0b pt=%0b",
                   a.cyc, ak_sig[3:0], a.addr, a.pass, a.acc, a.relu, a.pt,
                   e.cyc, ek_sig[3:0], e.addr, e.pass, e.acc, e.relu, e.pt);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic ev(input int off, input int kind, input int addr, input int pass,
                    input bit acc, input bit relu, input bit pt);
    ev_t e;
    e = '{t0 + off, kind, addr, pass, acc, relu, pt};
    q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc != c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at #1 after a rising edge; start is seen by the next edge.
  task automatic launch(input int rows, input int passes, input int base,
                        input bit relu, input bit pm);
    bus.num_rows   = AW'(rows);
    bus.num_passes = PW'(passes);
    bus.base_addr  = AW'(base);
    bus.relu_en    = relu;
    bus.pass_mode  = pm;
    bus.start      = 1'b1;
    goto(t0 + 1);
    bus.start      = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.busy) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending events busy=%0b, required 0 pending and idle",
               q.size(), bus.busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ofifo_rd"}, bus.ofifo_rd, 0);
    chk({tag, "_cen"}, bus.sram_cen, 1);
    chk({tag, "_wen"}, bus.sram_wen, 1);
    chk({tag, "_addr"}, bus.sram_addr, 0);
    chk({tag, "_accum"}, bus.sfp_accum, 0);
    chk({tag, "_relu"}, bus.sfp_relu, 0);
    chk({tag, "_pt"}, bus.sfp_passthrough, 0);
    chk({tag, "_pass_idx"}, bus.pass_idx, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.num_rows = '0; bus.num_passes = '0; bus.base_addr = '0;
    bus.relu_en = 1'b0; bus.pass_mode = 1'b0; bus.ofifo_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;

    // basic: 3 rows, 1 pass, base 10
    t0 = cyc;
    ev(3, K_WR, 10, 0, 0, 0, 0); ev(5, K_WR, 11, 0, 0, 0, 0);
    ev(7, K_WR, 12, 0, 0, 0, 0); ev(8, K_DONE, 0, 0, 0, 0, 0);
    launch(3, 1, 10, 0, 0);
    drain();

    // accumulation: 2 rows, 3 passes, relu on final pass
    t0 = cyc; pops = 0;
    ev(3, K_WR, 100, 0, 0, 0, 0); ev(5, K_WR, 101, 0, 0, 0, 0);
    ev(6, K_RD, 100, 1, 1, 0, 0); ev(7, K_WR, 100, 1, 1, 0, 0);
    ev(8, K_RD, 101, 1, 1, 0, 0); ev(9, K_WR, 101, 1, 1, 0, 0);
    ev(10, K_RD, 100, 2, 1, 1, 0); ev(11, K_WR, 100, 2, 1, 1, 0);
    ev(12, K_RD, 101, 2, 1, 1, 0); ev(13, K_WR, 101, 2, 1, 1, 0);
    ev(14, K_DONE, 0, 2, 1, 1, 0);
    launch(2, 3, 100, 1, 0);
    drain();
    chk("accum_pops", pops, 6);

    // OFIFO stall before row 1
    t0 = cyc;
    ev(3, K_WR, 20, 0, 0, 0, 0); ev(9, K_WR, 21, 0, 0, 0, 0);
    ev(11, K_WR, 22, 0, 0, 0, 0); ev(12, K_DONE, 0, 0, 0, 0, 0);
    launch(3, 1, 20, 0, 0);
    goto(t0 + 3); bus.ofifo_valid = 1'b0;
    goto(t0 + 5);
    @(negedge clk);
    chk("stall_busy", bus.busy, 1);
    goto(t0 + 7); bus.ofifo_valid = 1'b1;
    drain();

    // address wrap
    t0 = cyc;
    ev(3, K_WR, 2046, 0, 0, 0, 0); ev(5, K_WR, 2047, 0, 0, 0, 0);
    ev(7, K_WR, 0, 0, 0, 0, 0); ev(8, K_DONE, 0, 0, 0, 0, 0);
    launch(3, 1, 2046, 0, 0);
    drain();

    // empty jobs
    t0 = cyc; pops = 0;
    ev(1, K_DONE, 0, 0, 0, 0, 0);
    launch(0, 2, 5, 0, 0);
    drain();
    t0 = cyc;
    ev(1, K_DONE, 0, 0, 0, 0, 0);
    launch(4, 0, 5, 0, 0);
    drain();
    chk("empty_pops", pops, 0);

    // passthrough: 1 row, 2 passes, relu requested but masked
    t0 = cyc;
    ev(3, K_WR, 40, 0, 0, 0, 1); ev(5, K_WR, 40, 1, 0, 0, 1);
    ev(6, K_DONE, 0, 1, 0, 0, 1);
    launch(1, 2, 40, 1, 1);
    drain();

    // start while busy is ignored
    t0 = cyc;
    ev(3, K_WR, 10, 0, 0, 0, 0); ev(5, K_WR, 11, 0, 0, 0, 0);
    ev(6, K_DONE, 0, 0, 0, 0, 0);
    launch(2, 1, 10, 0, 0);
    goto(t0 + 2);
    bus.num_rows = AW'(5); bus.base_addr = AW'(500); bus.start = 1'b1;
    goto(t0 + 3);
    bus.start = 1'b0;
    drain();

    // reset during WR of an accumulating pass
    t0 = cyc;
    ev(3, K_WR, 30, 0, 0, 0, 0); ev(4, K_RD, 30, 1, 1, 0, 0);
    ev(5, K_WR, 30, 1, 1, 0, 0);
    launch(1, 2, 30, 0, 0);
    goto(t0 + 5);
    reset = 1'b1;
    goto(t0 + 6);
    reset = 1'b0;
    @(negedge clk);
    check_idle("midjob_reset");
    repeat (6) @(posedge clk);
    #1;
    chk("midjob_pending", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
